// File: rtl/mem_stage_if.sv
// Interface bundle between the execute stage and the memory stage of the
// five-stage MIPS pipeline. The master side (E / write-back) drives the
// E/M inputs and the store-data forward select. The slave side (mem_stage)
// returns the registered M-stage values and the load data.
interface mem_stage_if;
    logic [31:0] IR_E;
    logic [31:0] pc_E;
    logic [31:0] pc4_E;
    logic [31:0] ALUout_E;
    logic [31:0] data2_E;
    logic        fwd_rt_M;
    logic [31:0] WD_W;
    logic [31:0] IR_M;
    logic [31:0] pc_M;
    logic [31:0] pc4_M;
    logic [31:0] ALUout_M;
    logic [31:0] DMout_M;

    modport master (
        output IR_E, pc_E, pc4_E, ALUout_E, data2_E, fwd_rt_M, WD_W,
        input  IR_M, pc_M, pc4_M, ALUout_M, DMout_M
    );

    modport slave (
        input  IR_E, pc_E, pc4_E, ALUout_E, data2_E, fwd_rt_M, WD_W,
        output IR_M, pc_M, pc4_M, ALUout_M, DMout_M
    );
endinterface

// File: rtl/mem_stage.sv
// Memory stage of the five-stage MIPS pipeline.
// Holds the E/M pipeline register and a word-organised data memory that
// supports byte/half/word stores and sign/zero-extending loads. Load/store
// behaviour is decoded from the registered instruction word.
// Optional feature: define DM_TRACE_EN to print one trace line per committed
// store at the write edge; with it undefined the design has no display
// statements and behaves identically.
module mem_stage #(
    parameter int DM_WORDS = 4096,
    parameter int DM_AW    = 12
) (
    input  logic      clk,
    input  logic      reset,
    mem_stage_if.slave bus
);

    localparam logic [5:0] OP_SW  = 6'h2b;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LBU = 6'h24;

    logic [31:0] ir_q;
    logic [31:0] pc_q;
    logic [31:0] pc4_q;
    logic [31:0] alu_q;
    logic [31:0] data2_q;

    logic [31:0] mem [DM_WORDS];

    logic [5:0]       op;
    logic [DM_AW-1:0] word_idx;
    logic [4:0]       byte_shift;
    logic [31:0]      sd;
    logic [31:0]      rd_word;
    logic [31:0]      store_word;
    logic             is_store;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [31:0]      load_data;

    assign op         = ir_q[31:26];
    assign word_idx   = alu_q[DM_AW+1:2];
    assign byte_shift = {alu_q[1:0], 3'b000};

    // Store-data selection, read-modify-write lane merge and load extension
    // are all derived combinationally from the M registers and current memory.
    always_comb begin
        sd         = bus.fwd_rt_M ? bus.WD_W : data2_q;
        rd_word    = mem[word_idx];
        byte_sel   = rd_word[byte_shift +: 8];
        half_sel   = alu_q[1] ? rd_word[31:16] : rd_word[15:0];
        store_word = rd_word;
        is_store   = 1'b0;
        load_data  = '0;
        case (op)
            OP_SW: begin
                is_store   = 1'b1;
                store_word = sd;
            end
            OP_SH: begin
                is_store = 1'b1;
                if (alu_q[1]) begin
                    store_word[31:16] = sd[15:0];
                end else begin
                    store_word[15:0] = sd[15:0];
                end
            end
            OP_SB: begin
                is_store = 1'b1;
                store_word[byte_shift +: 8] = sd[7:0];
            end
            OP_LW:  load_data = rd_word;
            OP_LH:  load_data = {{16{half_sel[15]}}, half_sel};
            OP_LHU: load_data = {16'h0000, half_sel};
            OP_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU: load_data = {24'h000000, byte_sel};
            default: load_data = '0;
        endcase
    end

    // E/M pipeline register and memory write; reset clears both and
    // suppresses any store sitting in M on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            ir_q    <= '0;
            pc_q    <= '0;
            pc4_q   <= '0;
            alu_q   <= '0;
            data2_q <= '0;
            for (int i = 0; i < DM_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            ir_q    <= bus.IR_E;
            pc_q    <= bus.pc_E;
            pc4_q   <= bus.pc4_E;
            alu_q   <= bus.ALUout_E;
            data2_q <= bus.data2_E;
            if (is_store) begin
                mem[word_idx] <= store_word;
`ifdef DM_TRACE_EN
                $display("%d@%h: *%h <= %h", $time, pc_q, {alu_q[31:2], 2'b00}, store_word);
`endif
            end
        end
    end

    assign bus.IR_M     = ir_q;
    assign bus.pc_M     = pc_q;
    assign bus.pc4_M    = pc4_q;
    assign bus.ALUout_M = alu_q;
    assign bus.DMout_M  = load_data;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed scenarios followed by random traffic,
// compared against a byte-addressed little-endian memory model.
module tb_mem_stage;

    localparam int MEM_BYTES = 4096 * 4;

    localparam logic [5:0] SW  = 6'h2b;
    localparam logic [5:0] SH  = 6'h29;
    localparam logic [5:0] SB  = 6'h28;
    localparam logic [5:0] LW  = 6'h23;
    localparam logic [5:0] LH  = 6'h21;
    localparam logic [5:0] LHU = 6'h25;
    localparam logic [5:0] LB  = 6'h20;
    localparam logic [5:0] LBU = 6'h24;

    logic clk;
    logic reset;
    mem_stage_if bus();

    mem_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks;
    int failures;

    logic [7:0]  mem_b [MEM_BYTES];
    logic [31:0] m_ir, m_pc, m_pc4, m_alu, m_d2, m_wd;
    logic        m_fwd;

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [31:0] modelLoad(input logic [31:0] ir, input logic [31:0] alu);
        int unsigned a, base, h;
        logic [15:0] half;
        logic [7:0]  b;
        a    = alu % MEM_BYTES;
        base = a - (a % 4);
        h    = (a % 4) / 2;
        half = {mem_b[base + 2*h + 1], mem_b[base + 2*h]};
        b    = mem_b[a];
        case (ir[31:26])
            LW:  return {mem_b[base+3], mem_b[base+2], mem_b[base+1], mem_b[base]};
            LH:  return {{16{half[15]}}, half};
            LHU: return {16'h0, half};
            LB:  return {{24{b[7]}}, b};
            LBU: return {24'h0, b};
            default: return 32'h0;
        endcase
    endfunction

    task automatic modelCommit();
        int unsigned a, base, h;
        logic [31:0] sd;
        a    = m_alu % MEM_BYTES;
        base = a - (a % 4);
        h    = (a % 4) / 2;
        sd   = m_fwd ? m_wd : m_d2;
        case (m_ir[31:26])
            SW: for (int k = 0; k < 4; k++) mem_b[base + k] = sd[8*k +: 8];
            SH: begin
                mem_b[base + 2*h]     = sd[7:0];
                mem_b[base + 2*h + 1] = sd[15:8];
            end
            SB: mem_b[a] = sd[7:0];
            default: ;
        endcase
    endtask

    // One pipeline cycle: present E inputs, let the edge happen, then set the
    // M-cycle forward controls and compare every M output with the model.
    task automatic applyStimulus(input logic rst, input logic [31:0] ir, input logic [31:0] alu,
                                 input logic [31:0] d2, input logic fwd, input logic [31:0] wd);
        logic [31:0] pc;
        pc            = $urandom & 32'hFFFF_FFFC;
        reset         = rst;
        bus.IR_E      = ir;
        bus.pc_E      = pc;
        bus.pc4_E     = pc + 32'd4;
        bus.ALUout_E  = alu;
        bus.data2_E   = d2;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < MEM_BYTES; i++) mem_b[i] = 8'h00;
            m_ir = '0; m_pc = '0; m_pc4 = '0; m_alu = '0; m_d2 = '0;
        end else begin
            modelCommit();
            m_ir = ir; m_pc = pc; m_pc4 = pc + 32'd4; m_alu = alu; m_d2 = d2;
        end
        #1;
        bus.fwd_rt_M = fwd;
        bus.WD_W     = wd;
        m_fwd        = fwd;
        m_wd         = wd;
        #1;
        checkOutput("IR_M",     bus.IR_M,     m_ir);
        checkOutput("pc_M",     bus.pc_M,     m_pc);
        checkOutput("pc4_M",    bus.pc4_M,    m_pc4);
        checkOutput("ALUout_M", bus.ALUout_M, m_alu);
        checkOutput("DMout_M",  bus.DMout_M,  modelLoad(m_ir, m_alu));
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op);
        return {op, 26'($urandom)};
    endfunction

    logic [5:0] ops [10];

    // Main sequence: reset, directed store/load scenarios, random traffic,
    // then reset over a pending store.
    initial begin
        checks       = 0;
        failures     = 0;
        m_fwd        = 1'b0;
        m_wd         = '0;
        reset        = 1'b1;
        bus.fwd_rt_M = 1'b0;
        bus.WD_W     = '0;
        bus.IR_E     = '0;
        bus.pc_E     = '0;
        bus.pc4_E    = '0;
        bus.ALUout_E = '0;
        bus.data2_E  = '0;
        ops = '{SW, SH, SB, LW, LH, LHU, LB, LBU, 6'h00, 6'h0f};

        applyStimulus(1'b1, mk(SW), 32'h10, 32'h1111_1111, 1'b0, 32'h0);
        applyStimulus(1'b1, mk(LW), 32'h10, 32'h0, 1'b0, 32'h0);
        checkOutput("reset_IR_M", bus.IR_M, 32'h0);
        checkOutput("reset_pc_M", bus.pc_M, 32'h0);

        applyStimulus(1'b0, mk(SW), 32'h10, 32'h1234_5678, 1'b0, 32'h0);
        applyStimulus(1'b0, mk(LW), 32'h10, 32'h0, 1'b0, 32'h0);
        checkOutput("lw_after_sw", bus.DMout_M, 32'h1234_5678);

        applyStimulus(1'b0, mk(SB), 32'h13, 32'h0000_00AB, 1'b0, 32'h0);
        applyStimulus(1'b0, mk(LW), 32'h10, 32'h0, 1'b0, 32'h0);
        checkOutput("sb_merge", bus.DMout_M, 32'hAB34_5678);
        applyStimulus(1'b0, mk(LB), 32'h13, 32'h0, 1'b0, 32'h0);
        checkOutput("lb_sext", bus.DMout_M, 32'hFFFF_FFAB);
        applyStimulus(1'b0, mk(LBU), 32'h13, 32'h0, 1'b0, 32'h0);
        checkOutput("lbu_zext", bus.DMout_M, 32'h0000_00AB);

        applyStimulus(1'b0, mk(SH), 32'h12, 32'h0000_F00D, 1'b0, 32'h0);
        applyStimulus(1'b0, mk(LW), 32'h10, 32'h0, 1'b0, 32'h0);
        checkOutput("sh_merge", bus.DMout_M, 32'hF00D_5678);
        applyStimulus(1'b0, mk(LH), 32'h12, 32'h0, 1'b0, 32'h0);
        checkOutput("lh_sext", bus.DMout_M, 32'hFFFF_F00D);
        applyStimulus(1'b0, mk(LHU), 32'h10, 32'h0, 1'b0, 32'h0);
        checkOutput("lhu_zext", bus.DMout_M, 32'h0000_5678);

        applyStimulus(1'b0, mk(SW), 32'h20, 32'h0000_0001, 1'b1, 32'hDEAD_BEEF);
        applyStimulus(1'b0, mk(LW), 32'h20, 32'h0, 1'b0, 32'h0);
        checkOutput("sw_forward", bus.DMout_M, 32'hDEAD_BEEF);

        applyStimulus(1'b0, mk(SW), 32'h4010, 32'hCAFE_F00D, 1'b0, 32'h0);
        applyStimulus(1'b0, mk(LW), 32'h10, 32'h0, 1'b0, 32'h0);
        checkOutput("addr_alias", bus.DMout_M, 32'hCAFE_F00D);

        for (int n = 0; n < 400; n++) begin
            logic [31:0] alu;
            alu = $urandom & 32'hFFFF_C03F;
            applyStimulus(1'b0, mk(ops[$urandom_range(0, 9)]), alu, $urandom,
                          ($urandom_range(0, 3) == 0), $urandom);
        end

        applyStimulus(1'b0, mk(SW), 32'h10, 32'h55AA_55AA, 1'b0, 32'h0);
        applyStimulus(1'b1, mk(SW), 32'h14, 32'h1234_0000, 1'b0, 32'h0);
        checkOutput("rst_pending_ALUout", bus.ALUout_M, 32'h0);
        applyStimulus(1'b1, mk(LW), 32'h10, 32'h0, 1'b0, 32'h0);
        checkOutput("rst_hold_IR_M", bus.IR_M, 32'h0);
        applyStimulus(1'b0, mk(LW), 32'h10, 32'h0, 1'b0, 32'h0);
        checkOutput("rst_no_write", bus.DMout_M, 32'h0);
        for (int n = 0; n < 8; n++) begin
            applyStimulus(1'b0, mk(LW), $urandom & 32'h0000_003C, 32'h0, 1'b0, 32'h0);
            checkOutput("rst_cleared", bus.DMout_M, 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
